// File: rtl/draw_rect_char_if.sv
// Pixel-pipeline bundle for the text-box overlay: incoming VGA timing and
// background colour, the two ROM lookup paths, and the delayed outputs.
interface draw_rect_char_if;
  logic [10:0] hcount_in;
  logic [10:0] vcount_in;
  logic        hsync_in;
  logic        hblnk_in;
  logic        vsync_in;
  logic        vblnk_in;
  logic [11:0] rgb_in;
  logic        en;
  logic [7:0]  char_line_pixels;

  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [10:0] hcount_out;
  logic [10:0] vcount_out;
  logic        hsync_out;
  logic        hblnk_out;
  logic        vsync_out;
  logic        vblnk_out;
  logic [11:0] rgb_out;

  // Overlay stage view
  modport slave (
    input  hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in,
           rgb_in, en, char_line_pixels,
    output char_xy, char_line, hcount_out, vcount_out, hsync_out, hblnk_out,
           vsync_out, vblnk_out, rgb_out
  );

  // Upstream timing source / ROM side view
  modport master (
    output hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in,
           rgb_in, en, char_line_pixels,
    input  char_xy, char_line, hcount_out, vcount_out, hsync_out, hblnk_out,
           vsync_out, vblnk_out, rgb_out
  );
endinterface

// File: rtl/draw_rect_char.sv
// Text-box overlay: addresses the char-code and font ROMs from the pixel
// position, then paints set glyph pixels over the background. Timing is
// carried through a fixed pipeline so it lines up with the two ROM reads.
module draw_rect_char #(
  parameter logic [10:0] XPOS         = 11'd100,
  parameter logic [10:0] YPOS         = 11'd50,
  parameter logic [11:0] LETTER_COLOR = 12'hFFF
) (
  input logic             clk,
  input logic             rst_n,
  draw_rect_char_if.slave bus
);

  localparam int unsigned BOX_W  = 128;
  localparam int unsigned BOX_H  = 256;
  localparam int unsigned CMP_W  = 12;
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned POS_W  = 11;
  // Timing bundle layout: {hcount, vcount, hsync, hblnk, vsync, vblnk, rgb}
  localparam int unsigned TIM_W  = 2 * POS_W + 4 + RGB_W;
  localparam int unsigned VB_BIT = RGB_W;
  localparam int unsigned VS_BIT = RGB_W + 1;
  localparam int unsigned HB_BIT = RGB_W + 2;

  logic [CMP_W-1:0] x_lo, x_hi, y_lo, y_hi;
  logic             in_box_c;
  logic [6:0]       dx_c;
  logic [7:0]       dy_c;
  logic [TIM_W-1:0] tim_in_c;

  logic [7:0]       char_xy_q;
  logic [3:0]       line1;
  logic [2:0]       xoff1, xoff2, xoff3;
  logic             draw1, draw2, draw3;
  logic [TIM_W-1:0] tim1, tim2, tim3, tim_out;
  logic [3:0]       char_line_q;

  logic             pixel_on_c;
  logic [RGB_W-1:0] rgb_next_c;

  // Box bounds widened by one bit so the right/bottom limits cannot wrap
  assign x_lo = CMP_W'(XPOS);
  assign x_hi = CMP_W'(XPOS) + CMP_W'(BOX_W);
  assign y_lo = CMP_W'(YPOS);
  assign y_hi = CMP_W'(YPOS) + CMP_W'(BOX_H);

  assign in_box_c = ({1'b0, bus.hcount_in} >= x_lo) && ({1'b0, bus.hcount_in} < x_hi) &&
                    ({1'b0, bus.vcount_in} >= y_lo) && ({1'b0, bus.vcount_in} < y_hi);

  // Only the low bits of the box-relative offsets are needed: col/xoff and row/line
  assign dx_c = 7'(bus.hcount_in - XPOS);
  assign dy_c = 8'(bus.vcount_in - YPOS);

  assign tim_in_c = {bus.hcount_in, bus.vcount_in, bus.hsync_in, bus.hblnk_in,
                     bus.vsync_in, bus.vblnk_in, bus.rgb_in};

  // Stage 1: char-code ROM address plus position-derived side data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_xy_q <= '0;
      line1     <= '0;
      xoff1     <= '0;
      draw1     <= 1'b0;
      tim1      <= '0;
    end else begin
      char_xy_q <= in_box_c ? {dy_c[7:4], dx_c[6:3]} : 8'h00;
      line1     <= dy_c[3:0];
      xoff1     <= dx_c[2:0];
      draw1     <= in_box_c & bus.en;
      tim1      <= tim_in_c;
    end
  end

  // Stage 2: glyph line lands together with the char-code ROM output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_line_q <= '0;
      xoff2       <= '0;
      draw2       <= 1'b0;
      tim2        <= '0;
    end else begin
      char_line_q <= line1;
      xoff2       <= xoff1;
      draw2       <= draw1;
      tim2        <= tim1;
    end
  end

  // Stage 3: wait out the font ROM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xoff3 <= '0;
      draw3 <= 1'b0;
      tim3  <= '0;
    end else begin
      xoff3 <= xoff2;
      draw3 <= draw2;
      tim3  <= tim2;
    end
  end

  // Pick the current glyph bit (MSB is leftmost) and suppress it during blanking
  always_comb begin
    pixel_on_c = 1'b0;
    rgb_next_c = tim3[RGB_W-1:0];
    if (draw3 && !tim3[HB_BIT] && !tim3[VB_BIT]) begin
      pixel_on_c = bus.char_line_pixels[3'd7 - xoff3];
    end
    if (pixel_on_c) begin
      rgb_next_c = LETTER_COLOR;
    end
  end

  // Output register: delayed timing with the composited colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tim_out <= '0;
    end else begin
      tim_out <= {tim3[TIM_W-1:RGB_W], rgb_next_c};
    end
  end

  assign bus.char_xy    = char_xy_q;
  assign bus.char_line  = char_line_q;
  assign bus.hcount_out = tim_out[TIM_W-1 -: POS_W];
  assign bus.vcount_out = tim_out[TIM_W-POS_W-1 -: POS_W];
  assign bus.hsync_out  = tim_out[HB_BIT+1];
  assign bus.hblnk_out  = tim_out[HB_BIT];
  assign bus.vsync_out  = tim_out[VS_BIT];
  assign bus.vblnk_out  = tim_out[VB_BIT];
  assign bus.rgb_out    = tim_out[RGB_W-1:0];

endmodule
